// File: rtl/regfile_wport_sched.sv
// regfile_wport_sched: write-port scheduler for the 16x32 register file.
// ALU single writes and LDM burst beats share one write port. Contested
// cycles are arbitrated round-robin. Registers that still have LDM beats
// pending are tracked so that decode reads and ALU writes to them are held.
// Optional feature macro: REGFILE_WPORT_BYPASS_EN forwards the in-flight
// write to the A/B read outputs instead of stalling on it.
module regfile_wport_sched #(
  parameter int AW   = 4,
  parameter int DW   = 32,
  parameter int NREG = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_req,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_gnt,
  input  logic          ldm_start,
  input  logic [NREG-1:0] ldm_list,
  input  logic          ldm_valid,
  input  logic [DW-1:0] ldm_data,
  output logic          ldm_ready,
  output logic          ldm_busy,
  output logic          ldm_done,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic          rd_stall,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [AW-1:0] rf_ra,
  output logic [AW-1:0] rf_rb,
  input  logic [DW-1:0] rf_a,
  input  logic [DW-1:0] rf_b,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [NREG-1:0] pend_reg, pend_next;
  logic            rr_ldm_reg, rr_ldm_next;   // 1: LDM has priority on the next contest
  logic            done_reg, done_next;
  logic            we_reg;
  logic [AW-1:0]   waddr_reg;
  logic [DW-1:0]   wdata_reg;

  // Lowest-set-bit selection of the pending list.
  logic [NREG:0]   seen;
  logic [NREG-1:0] tgt_onehot;
  logic [AW-1:0]   tgt_addr;
  logic [NREG-1:0] pend_after_beat;

  logic in_burst;
  logic alu_elig;
  logic ldm_req;
  logic alu_win;
  logic ldm_accept;
  logic contested;

  assign seen[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_lsb
      assign seen[gi+1]     = seen[gi] | pend_reg[gi];
      assign tgt_onehot[gi] = pend_reg[gi] & ~seen[gi];
    end
  endgenerate

  // Encode the one-hot LDM target into a register address.
  always_comb begin
    tgt_addr = '0;
    for (int i = 0; i < NREG; i++) begin
      if (tgt_onehot[i]) tgt_addr = AW'(i);
    end
  end

  assign pend_after_beat = pend_reg & ~tgt_onehot;

  // Arbitration: an ALU write to a register still owed an LDM beat is held
  // back so the older LDM stays ordered ahead of it.
  assign in_burst   = (state_reg == BURST);
  assign alu_elig   = alu_req & ~pend_reg[alu_addr];
  assign ldm_req    = in_burst & ldm_valid;
  assign contested  = alu_elig & ldm_req;
  assign alu_win    = alu_elig & (~ldm_req | ~rr_ldm_reg);
  assign ldm_ready  = in_burst & (~alu_elig | rr_ldm_reg);
  assign ldm_accept = ldm_valid & ldm_ready;
  assign alu_gnt    = alu_win;

  // State register plus burst bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      pend_reg   <= '0;
      rr_ldm_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pend_reg   <= pend_next;
      rr_ldm_reg <= rr_ldm_next;
      done_reg   <= done_next;
    end
  end

  // Next-state logic for the burst FSM and pending list.
  always_comb begin
    state_next  = state_reg;
    pend_next   = pend_reg;
    done_next   = 1'b0;
    rr_ldm_next = rr_ldm_reg;
    if (contested) rr_ldm_next = alu_win;     // pointer moves to the loser
    case (state_reg)
      IDLE: begin
        if (ldm_start) begin
          if (ldm_list != '0) begin
            pend_next  = ldm_list;
            state_next = BURST;
          end else begin
            done_next = 1'b1;                 // empty list completes at once
          end
        end
      end
      BURST: begin
        if (ldm_accept) begin
          pend_next = pend_after_beat;
          if (pend_after_beat == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ldm_busy = in_burst;
    ldm_done = done_reg;
  end

  // One-cycle write pipeline towards the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      we_reg <= alu_win | ldm_accept;
      if (ldm_accept) begin
        waddr_reg <= tgt_addr;
        wdata_reg <= ldm_data;
      end else if (alu_win) begin
        waddr_reg <= alu_addr;
        wdata_reg <= alu_data;
      end
    end
  end

  assign rf_we    = we_reg;
  assign rf_waddr = waddr_reg;
  assign rf_wdata = wdata_reg;
  assign rf_ra    = ra;
  assign rf_rb    = rb;

  logic hit_a, hit_b;
  assign hit_a = we_reg & (waddr_reg == ra);
  assign hit_b = we_reg & (waddr_reg == rb);

`ifdef REGFILE_WPORT_BYPASS_EN
  // In-flight write is forwarded, so only pending LDM targets stall.
  assign a        = hit_a ? wdata_reg : rf_a;
  assign b        = hit_b ? wdata_reg : rf_b;
  assign rd_stall = pend_reg[ra] | pend_reg[rb];
`else
  // No forwarding: the uncommitted write also stalls decode.
  assign a        = rf_a;
  assign b        = rf_b;
  assign rd_stall = pend_reg[ra] | pend_reg[rb] | hit_a | hit_b;
`endif

endmodule

// File: tb/tb_regfile_wport_sched.sv
// Self-checking bench for regfile_wport_sched: expected register-file writes
// are queued when stimulus is driven and compared as the write port fires.
module tb_regfile_wport_sched;

  logic        clk;
  logic        rst;
  logic        alu_req;
  logic [3:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_gnt;
  logic        ldm_start;
  logic [15:0] ldm_list;
  logic        ldm_valid;
  logic [31:0] ldm_data;
  logic        ldm_ready;
  logic        ldm_busy;
  logic        ldm_done;
  logic [3:0]  ra, rb;
  logic        rd_stall;
  logic [31:0] a, b;
  logic [3:0]  rf_ra, rf_rb;
  logic [31:0] rf_a, rf_b;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;

  regfile_wport_sched dut (
    .clk(clk), .rst(rst),
    .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_gnt(alu_gnt),
    .ldm_start(ldm_start), .ldm_list(ldm_list), .ldm_valid(ldm_valid),
    .ldm_data(ldm_data), .ldm_ready(ldm_ready), .ldm_busy(ldm_busy), .ldm_done(ldm_done),
    .ra(ra), .rb(rb), .rd_stall(rd_stall), .a(a), .b(b),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_a(rf_a), .rf_b(rf_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every register-file write must match the oldest expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got write R%0d=%h at cycle %0d, required no write",
                 rf_waddr, rf_wdata, cyc);
      end else begin
        e_mon = sb.pop_front();
        if (rf_waddr !== e_mon.addr || rf_wdata !== e_mon.data || cyc !== e_mon.cyc) begin
          n_fail++;
          $display("FAIL wr_match: got R%0d=%h at cycle %0d, required R%0d=%h at cycle %0d",
                   rf_waddr, rf_wdata, cyc, e_mon.addr, e_mon.data, e_mon.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alu_req = 1'b0; ldm_start = 1'b0; ldm_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    ra = 4'd0; rb = 4'd0;
    #1;
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== 4'd0 || rf_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_wport: got we=%b addr=%0d data=%h, required 0/0/0",
               rf_we, rf_waddr, rf_wdata);
    end
    n_cmp++;
    if ({alu_gnt, ldm_ready, ldm_busy, ldm_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got gnt/ready/busy/done=%b, required 0000",
               {alu_gnt, ldm_ready, ldm_busy, ldm_done});
    end
    n_cmp++;
    if (rd_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b, required 0", rd_stall);
    end
  endtask

  task automatic test_alu_single();
    tick();
    alu_req = 1'b1; alu_addr = 4'd3; alu_data = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (alu_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_gnt: got %b, required 1", alu_gnt);
    end
    sb.push_back('{4'd3, 32'hDEADBEEF, cyc + 1});
    tick();
    alu_req = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_we_drop: got %b, required 0", rf_we);
    end
  endtask

  task automatic test_ldm_burst();
    logic [3:0]  tgt [4] = '{4'd0, 4'd2, 4'd4, 4'd15};
    logic [31:0] dat [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic        exp_stall;
    tick();
    ldm_start = 1'b1; ldm_list = 16'h8015; ra = 4'd4; rb = 4'd5;
    #1;
    n_cmp++;
    if (ldm_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ldm_busy_idle: got %b, required 0", ldm_busy);
    end
    tick();
    ldm_start = 1'b0; ldm_list = 16'h0;
    alu_req = 1'b1; alu_addr = 4'd15; alu_data = 32'hCAFE0015;
    #1;
    n_cmp++;
    if (ldm_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ldm_busy_burst: got %b, required 1", ldm_busy);
    end
    for (int i = 0; i < 4; i++) begin
      ldm_valid = 1'b1; ldm_data = dat[i];
`ifdef REGFILE_WPORT_BYPASS_EN
      exp_stall = (i < 3);
`else
      exp_stall = 1'b1;
`endif
      #1;
      n_cmp++;
      if (ldm_ready !== 1'b1 || alu_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL ldm_beat%0d: got ready=%b gnt=%b, required ready=1 gnt=0",
                 i, ldm_ready, alu_gnt);
      end
      n_cmp++;
      if (rd_stall !== exp_stall) begin
        n_fail++;
        $display("FAIL ldm_stall%0d: got %b, required %b", i, rd_stall, exp_stall);
      end
      sb.push_back('{tgt[i], dat[i], cyc + 1});
      tick();
    end
    ldm_valid = 1'b0;
    #1;
    n_cmp++;
    if (ldm_done !== 1'b1 || ldm_busy !== 1'b0 || ldm_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ldm_end: got done=%b busy=%b ready=%b, required 1/0/0",
               ldm_done, ldm_busy, ldm_ready);
    end
    n_cmp++;
    if (alu_gnt !== 1'b1 || rd_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL ldm_release: got gnt=%b stall=%b, required gnt=1 stall=0",
               alu_gnt, rd_stall);
    end
    sb.push_back('{4'd15, 32'hCAFE0015, cyc + 1});
    tick();
    alu_req = 1'b0;
    #1;
    n_cmp++;
    if (ldm_done !== 1'b0) begin
      n_fail++;
      $display("FAIL ldm_done_once: got %b, required 0", ldm_done);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic        alu_turn;
    logic [3:0]  ldm_tgt;
    do_reset();
    tick();
    ldm_start = 1'b1; ldm_list = 16'h0300; ra = 4'd0; rb = 4'd0;
    tick();
    ldm_start = 1'b0; ldm_list = 16'h0;
    for (int i = 0; i < 4; i++) begin
      alu_req = 1'b1; alu_addr = 4'd1; alu_data = 32'h100 + i;
      ldm_valid = 1'b1; ldm_data = 32'h200 + i;
      alu_turn = ((i % 2) == 0);
      ldm_tgt  = (i == 1) ? 4'd8 : 4'd9;
      #1;
      n_cmp++;
      if (alu_gnt !== alu_turn || ldm_ready !== !alu_turn) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got gnt=%b ready=%b, required gnt=%b ready=%b",
                 i, alu_gnt, ldm_ready, alu_turn, !alu_turn);
      end
      if (i > 0) begin
        n_cmp++;
        if (rf_we !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_gap%0d: got we=%b, required 1", i, rf_we);
        end
      end
      if (alu_turn) sb.push_back('{4'd1, 32'h100 + i, cyc + 1});
      else          sb.push_back('{ldm_tgt, 32'h200 + i, cyc + 1});
      tick();
    end
    alu_req = 1'b0; ldm_valid = 1'b0;
    #1;
    n_cmp++;
    if (rf_we !== 1'b1 || ldm_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_end: got we=%b done=%b, required 1/1", rf_we, ldm_done);
    end
    tick();
    tick();
  endtask

  task automatic test_empty_and_abort();
    tick();
    ldm_start = 1'b1; ldm_list = 16'h0;
    #1;
    tick();
    ldm_start = 1'b0;
    #1;
    n_cmp++;
    if (ldm_done !== 1'b1 || ldm_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_done: got done=%b busy=%b, required 1/0", ldm_done, ldm_busy);
    end
    tick();
    #1;
    n_cmp++;
    if (ldm_done !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_done_pulse: got %b, required 0", ldm_done);
    end
    ldm_start = 1'b1; ldm_list = 16'h00F0;
    tick();
    ldm_start = 1'b0; ldm_list = 16'h0;
    ldm_valid = 1'b1; ldm_data = 32'h77; ra = 4'd5; rb = 4'd0;
    #1;
    n_cmp++;
    if (ldm_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready: got %b, required 1", ldm_ready);
    end
    sb.push_back('{4'd4, 32'h77, cyc + 1});
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rd_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pend_stall: got %b, required 1", rd_stall);
    end
    tick();
    rst = 1'b0; ldm_valid = 1'b0;
    #1;
    n_cmp++;
    if (ldm_busy !== 1'b0 || rf_we !== 1'b0 || ldm_ready !== 1'b0 || rd_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got busy=%b we=%b ready=%b stall=%b, required 0000",
               ldm_busy, rf_we, ldm_ready, rd_stall);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ldm_done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done%0d: got %b, required 0", i, ldm_done);
      end
      tick();
      #1;
    end
  endtask

  task automatic test_read_hazard();
    logic        exp_stall;
    logic [31:0] exp_a, exp_b;
    tick();
    alu_req = 1'b1; alu_addr = 4'd7; alu_data = 32'h12345678; ra = 4'd0; rb = 4'd0;
    #1;
    n_cmp++;
    if (alu_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL haz_gnt: got %b, required 1", alu_gnt);
    end
    sb.push_back('{4'd7, 32'h12345678, cyc + 1});
    tick();
    alu_req = 1'b0; ra = 4'd7; rb = 4'd7;
`ifdef REGFILE_WPORT_BYPASS_EN
    exp_stall = 1'b0; exp_a = 32'h12345678; exp_b = 32'h12345678;
`else
    exp_stall = 1'b1; exp_a = 32'hAAAA0001; exp_b = 32'hBBBB0002;
`endif
    #1;
    n_cmp++;
    if (rf_ra !== 4'd7 || rf_rb !== 4'd7) begin
      n_fail++;
      $display("FAIL haz_raddr: got ra=%0d rb=%0d, required 7/7", rf_ra, rf_rb);
    end
    n_cmp++;
    if (rd_stall !== exp_stall || a !== exp_a || b !== exp_b) begin
      n_fail++;
      $display("FAIL haz_inflight: got stall=%b a=%h b=%h, required stall=%b a=%h b=%h",
               rd_stall, a, b, exp_stall, exp_a, exp_b);
    end
    tick();
    #1;
    n_cmp++;
    if (rd_stall !== 1'b0 || a !== 32'hAAAA0001) begin
      n_fail++;
      $display("FAIL haz_after: got stall=%b a=%h, required 0/aaaa0001", rd_stall, a);
    end
  endtask

  initial begin
    rst = 1'b1;
    alu_req = 1'b0; alu_addr = 4'd0; alu_data = 32'd0;
    ldm_start = 1'b0; ldm_list = 16'd0; ldm_valid = 1'b0; ldm_data = 32'd0;
    ra = 4'd0; rb = 4'd0;
    rf_a = 32'hAAAA0001; rf_b = 32'hBBBB0002;

    test_reset();
    test_alu_single();
    test_ldm_burst();
    test_round_robin();
    test_empty_and_abort();
    test_read_hazard();

    tick();
    tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d writes outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
